// File: rtl/data_sram_responder.sv
// Purpose: slave end of the EX/MEM data-SRAM port; byte-granular writes, registered read data.
// Latency: LATENCY cycles from the accept edge to valid rdata (1..4).
// Backpressure: no ready signal; raises stallreq so EX holds the request until the access completes.
module data_sram_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [31:0]       data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic [31:0]       data_sram_rdata,
  output logic              stallreq
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam bit         SINGLE   = (LATENCY == 1);
  localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

  generate
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("data_sram_responder: LATENCY must be in 1..4");
    end
  endgenerate

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [1:0]          cnt;
  logic [1:0]          cnt_nxt;

  logic [ADDR_W-1:0]   req_idx;
  logic [3:0]          req_wen;
  logic [31:0]         req_wdata;

  logic [31:0]         mem [0:DEPTH-1];

  logic                accept;
  logic                done;
  logic [ADDR_W-1:0]   acc_idx;
  logic [3:0]          acc_wen;
  logic [31:0]         acc_wdata;
  logic                commit_wr;
  logic                commit_rd;
  logic                unused_addr_bits;

  // Word index comes from addr[ADDR_W+1:2]; byte offset and upper bits alias.
  assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  assign accept = (state == IDLE) && data_sram_en;

  // Single-cycle mode completes on the accept edge using the live request;
  // multi-cycle mode completes on the last BUSY edge using the captured one.
  assign done      = SINGLE ? accept : ((state == BUSY) && (cnt == 2'd1));
  assign acc_idx   = SINGLE ? data_sram_addr[ADDR_W+1:2] : req_idx;
  assign acc_wen   = SINGLE ? data_sram_wen   : req_wen;
  assign acc_wdata = SINGLE ? data_sram_wdata : req_wdata;

  // Gate with rst so nothing lands in the array while reset is held.
  assign commit_wr = rst && done && (acc_wen != 4'b0000);
  assign commit_rd = done && (acc_wen == 4'b0000);

  // Stall EX while the access cannot finish by the time it reaches MEM.
  assign stallreq = rst && (((state == IDLE) && data_sram_en && !SINGLE) ||
                            ((state == BUSY) && (cnt > 2'd1)));

  // Next-state and countdown for the multi-cycle access.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept && !SINGLE) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt > 2'd1) begin
          cnt_nxt = cnt - 2'd1;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = 2'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 2'd0;
      end
    endcase
  end

  // State and counter registers; reset aborts any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture the request on accept; it is replayed at the completion edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_idx   <= '0;
      req_wen   <= 4'b0000;
      req_wdata <= 32'h0;
    end else if (accept) begin
      req_idx   <= data_sram_addr[ADDR_W+1:2];
      req_wen   <= data_sram_wen;
      req_wdata <= data_sram_wdata;
    end
  end

  // Byte-lane write into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wen[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read data; writes leave it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_sram_rdata <= 32'h0;
    end else if (commit_rd) begin
      data_sram_rdata <= mem[acc_idx];
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench: three responders at LATENCY 1, 2 and 3 share one clock.
// Each is exercised in turn while the others sit idle.
module tb_data_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // LATENCY=1 instance
  logic        rst1, en1, stall1;
  logic [3:0]  wen1;
  logic [31:0] addr1, wdata1, rdata1;
  // LATENCY=2 instance
  logic        rst2, en2, stall2;
  logic [3:0]  wen2;
  logic [31:0] addr2, wdata2, rdata2;
  // LATENCY=3 instance
  logic        rst3, en3, stall3;
  logic [3:0]  wen3;
  logic [31:0] addr3, wdata3, rdata3;

  data_sram_responder #(.ADDR_W(12), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst1), .data_sram_en(en1), .data_sram_wen(wen1),
    .data_sram_addr(addr1), .data_sram_wdata(wdata1),
    .data_sram_rdata(rdata1), .stallreq(stall1));

  data_sram_responder #(.ADDR_W(12), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst2), .data_sram_en(en2), .data_sram_wen(wen2),
    .data_sram_addr(addr2), .data_sram_wdata(wdata2),
    .data_sram_rdata(rdata2), .stallreq(stall2));

  data_sram_responder #(.ADDR_W(12), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst3), .data_sram_en(en3), .data_sram_wen(wen3),
    .data_sram_addr(addr3), .data_sram_wdata(wdata3),
    .data_sram_rdata(rdata3), .stallreq(stall3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge so outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req1(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en1 = e; wen1 = w; addr1 = a; wdata1 = d;
  endtask

  task automatic req2(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en2 = e; wen2 = w; addr2 = a; wdata2 = d;
  endtask

  task automatic req3(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en3 = e; wen3 = w; addr3 = a; wdata3 = d;
  endtask

  initial begin
    rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    req1(1'b0, 4'h0, 32'h0, 32'h0);
    req2(1'b0, 4'h0, 32'h0, 32'h0);
    req3(1'b0, 4'h0, 32'h0, 32'h0);
    #2;
    check("rst_rdata_l1", rdata1, 32'h0);
    check("rst_stall_l1", {31'b0, stall1}, 32'h0);
    check("rst_rdata_l2", rdata2, 32'h0);
    check("rst_rdata_l3", rdata3, 32'h0);
    check("rst_stall_l3", {31'b0, stall3}, 32'h0);
    tick();
    rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    tick();

    // ---------------- LATENCY=1 ----------------
    req1(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF);
    #1 check("l1_wr_stall", {31'b0, stall1}, 32'h0);
    tick();
    check("l1_wr_no_writethrough", rdata1, 32'h0);
    req1(1'b1, 4'b0000, 32'h10, 32'h0);
    #1 check("l1_rd_stall", {31'b0, stall1}, 32'h0);
    tick();
    check("l1_rd_full", rdata1, 32'hDEADBEEF);

    req1(1'b1, 4'b0010, 32'h10, 32'h00005500);
    tick();
    check("l1_partial_wr_hold", rdata1, 32'hDEADBEEF);
    req1(1'b1, 4'b0000, 32'h10, 32'h0);
    tick();
    check("l1_rd_partial", rdata1, 32'hDEAD55EF);
    req1(1'b1, 4'b0000, 32'h13, 32'h0);
    tick();
    check("l1_rd_offset_ignored", rdata1, 32'hDEAD55EF);

    req1(1'b1, 4'b1111, 32'h20, 32'h12345678);
    tick();
    req1(1'b1, 4'b1111, 32'h4000, 32'hA5A5A5A5);
    tick();
    req1(1'b1, 4'b0000, 32'h0, 32'h0);
    tick();
    check("l1_wrap", rdata1, 32'hA5A5A5A5);

    req1(1'b1, 4'b0000, 32'h10, 32'h0);
    tick();
    check("l1_b2b_0", rdata1, 32'hDEAD55EF);
    req1(1'b1, 4'b0000, 32'h20, 32'h0);
    tick();
    check("l1_b2b_1", rdata1, 32'h12345678);
    req1(1'b1, 4'b0000, 32'h10, 32'h0);
    tick();
    check("l1_b2b_2", rdata1, 32'hDEAD55EF);
    check("l1_b2b_stall", {31'b0, stall1}, 32'h0);
    req1(1'b0, 4'h0, 32'h0, 32'h0);
    tick();

    // ---------------- LATENCY=3 ----------------
    req3(1'b1, 4'b1111, 32'h20, 32'h12345678);
    tick();
    tick();
    tick();
    req3(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    // C0: read presented and held while stalled
    req3(1'b1, 4'b0000, 32'h20, 32'h0);
    #1 check("l3_stall_c0", {31'b0, stall3}, 32'h1);
    tick();
    check("l3_stall_c1", {31'b0, stall3}, 32'h1);
    check("l3_rdata_c1", rdata3, 32'h0);
    tick();
    check("l3_stall_c2", {31'b0, stall3}, 32'h0);
    check("l3_rdata_c2", rdata3, 32'h0);
    tick();
    check("l3_rdata_c3", rdata3, 32'h12345678);
    // C3: a new request is accepted
    req3(1'b1, 4'b1111, 32'h24, 32'h0BADBEEF);
    #1 check("l3_new_req_stall_c3", {31'b0, stall3}, 32'h1);
    tick();
    check("l3_new_req_busy", {31'b0, stall3}, 32'h1);
    check("l3_rdata_held", rdata3, 32'h12345678);
    tick();
    tick();
    req3(1'b1, 4'b0000, 32'h24, 32'h0);
    tick();
    tick();
    tick();
    req3(1'b0, 4'h0, 32'h0, 32'h0);
    check("l3_rd_second", rdata3, 32'h0BADBEEF);
    tick();

    // ---------------- LATENCY=2 ----------------
    req2(1'b1, 4'b1111, 32'h30, 32'h11111111);
    tick();
    req2(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    req2(1'b1, 4'b0000, 32'h30, 32'h0);
    tick();
    tick();
    check("l2_rd_pre", rdata2, 32'h11111111);
    req2(1'b1, 4'b1111, 32'h30, 32'hCAFEF00D);
    #1 check("l2_stall_accept", {31'b0, stall2}, 32'h1);
    tick();
    #2 rst2 = 1'b0;
    #1;
    check("l2_rst_rdata", rdata2, 32'h0);
    check("l2_rst_stall", {31'b0, stall2}, 32'h0);
    tick();
    req2(1'b0, 4'h0, 32'h0, 32'h0);
    rst2 = 1'b1;
    tick();
    req2(1'b1, 4'b0000, 32'h30, 32'h0);
    tick();
    req2(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    check("l2_write_dropped", rdata2, 32'h11111111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Slave end of the data-SRAM interface driven by the EX/MEM stages.
- Accepts the enable, byte-write-enable, address and write-data request issued in EX. Commits writes with byte granularity.
- Returns read data so it is valid in the cycle the request sits in MEM.
- For multi-cycle latency it raises a stall request to the pipeline stall controller until the access can complete on time.

Parameters:
ADDR_W, 12, word-index bits; array depth is 2^ADDR_W 32-bit words.
LATENCY, 1, cycles from accept edge to rdata valid; legal range 1..4 (elaboration error otherwise).

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
data_sram_en  input  1  request valid this cycle
data_sram_wen  input  4  byte write enables; 4'b0000 = read, bit i writes byte lane i (bits 8i+7:8i)
data_sram_addr  input  32  byte address; word index = addr[ADDR_W+1:2], addr[1:0] ignored, upper bits ignored
data_sram_wdata  input  32  write data, lane-aligned
data_sram_rdata  output  32  read data (registered)
stallreq  output  1  stall request to pipeline stall controller

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, data_sram_rdata=32'h0, stallreq=0 immediately. Array contents are NOT cleared.
- Reset mid-BUSY: access aborted, pending write dropped, no rdata update. First request after reset release is accepted normally.
- States: IDLE, BUSY. cnt is a 2-bit down-counter.
- Accept: rising edge with state=IDLE and en=1.
  - Captures word index, wen and wdata into request registers.
- LATENCY=1:
  - At the accept edge, the write commits (lanes with wen bit set). For a read, rdata is loaded with the array word.
  - State stays IDLE; stallreq is always 0.
  - Back-to-back requests are accepted every cycle.
- LATENCY=N>1:
  - At the accept edge: state->BUSY, cnt<=N-1.
  - In BUSY, cnt decrements on each edge while cnt>1.
  - Completion edge is BUSY with cnt==1: commit the write or load rdata using the captured request, then state->IDLE.
  - en, wen, addr and wdata are ignored throughout BUSY (the stalled EX stage keeps re-presenting the same request).
- stallreq (combinational) = (IDLE & en & LATENCY>1) | (BUSY & cnt>1).
  - The request is stalled in EX for N-1 extra cycles, so it enters MEM in the cycle rdata becomes valid.
- Write request: rdata holds its previous value; no write-through onto rdata.
- Read data reflects all previously completed writes. A read immediately following a write to the same word returns the merged new word, because the write commits before the read is accepted.
- Partial write: only enabled lanes change; other lanes keep their old bytes.
- Address wrap: indices above 2^ADDR_W-1 alias modulo the depth.

Test Plan:
- LATENCY=1, reset then write addr 0x10 wen=1111 wdata=0xDEADBEEF, next cycle read 0x10 -> rdata=0xDEADBEEF in the cycle after the read accept; stallreq stays 0.
- LATENCY=1, after the previous write, write 0x10 wen=0010 wdata=0x00005500, then read 0x10 -> rdata=0xDEAD55EF. A read of 0x13 returns the same word (addr[1:0] ignored).
- LATENCY=3, read 0x20 holding 0x12345678 with en held high while stalled -> stallreq=1 in accept cycle C0 and in C1, 0 in C2. rdata=0x12345678 from C3. Exactly one access occurs: a following new request in C3 is accepted.
- LATENCY=2, assert rst=0 mid-BUSY of a write 0x30 <= 0xCAFEF00D (old value 0x11111111) -> stallreq and rdata drop to 0 asynchronously. After release, a read of 0x30 returns 0x11111111.
- LATENCY=1, ADDR_W=12, write 0x4000 (index 4096) wdata=0xA5A5A5A5, then read 0x0 -> rdata=0xA5A5A5A5 (wrap-around).
- LATENCY=1, back-to-back reads of 0x10, 0x20, 0x10 on consecutive cycles -> rdata sequence 0xDEAD55EF, 0x12345678, 0xDEAD55EF with one-cycle latency and no bubbles.
